// File: rtl/pcie_axi_read_engine.sv
// pcie_axi_read_engine: pipelined PCIe-to-AXI-Lite read engine with in-order completion pairing
module pcie_axi_read_engine #(
    parameter int          AXI_ADDR_WIDTH  = 49,
    parameter int          AXI_DATA_WIDTH  = 64,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [63:0] BAR0AXI = 64'h0,
    parameter logic [63:0] BAR1AXI = 64'h0,
    parameter logic [63:0] BAR2AXI = 64'h0,
    parameter logic [63:0] BAR3AXI = 64'h0,
    parameter logic [63:0] BAR4AXI = 64'h0,
    parameter logic [63:0] BAR5AXI = 64'h0,
    parameter int          BAR0SIZE = 12,
    parameter int          BAR1SIZE = 12,
    parameter int          BAR2SIZE = 12,
    parameter int          BAR3SIZE = 12,
    parameter int          BAR4SIZE = 12,
    parameter int          BAR5SIZE = 12
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_areset,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic                      mem_req_valid,
    output logic                      mem_req_ready,
    input  logic [2:0]                mem_req_bar_hit,
    input  logic [31:0]               mem_req_pcie_address,
    input  logic [3:0]                mem_req_byte_enable,
    input  logic                      mem_req_write_readn,
    input  logic                      mem_req_phys_func,
    input  logic [63:0]               phy_addr,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [31:0]               cpl_data,
    output logic [3:0]                cpl_byte_enable,
    output logic                      cpl_phys_func,
    output logic [1:0]                cpl_status,
    output logic [4:0]                outstanding_cnt
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic       ur;
        logic       lane;
        logic [3:0] be;
        logic       func;
    } meta_t;

    meta_t          fifo_q [MAX_OUTSTANDING];
    meta_t          head;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [4:0]     cnt_q, cnt_d;
    logic [AW-1:0]  araddr_q, araddr_d;
    logic           arvalid_q, arvalid_d;
    logic           accept, mapped, empty, pop;
    logic [63:0]    bar_base, bar_mask, bar_addr, rdata64;
    int             bar_size;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        bar_base = mem_req_bar_hit == 3'd0 ? BAR0AXI :
                   mem_req_bar_hit == 3'd1 ? BAR1AXI :
                   mem_req_bar_hit == 3'd2 ? BAR2AXI :
                   mem_req_bar_hit == 3'd3 ? BAR3AXI :
                   mem_req_bar_hit == 3'd4 ? BAR4AXI : BAR5AXI;
        bar_size = mem_req_bar_hit == 3'd0 ? BAR0SIZE :
                   mem_req_bar_hit == 3'd1 ? BAR1SIZE :
                   mem_req_bar_hit == 3'd2 ? BAR2SIZE :
                   mem_req_bar_hit == 3'd3 ? BAR3SIZE :
                   mem_req_bar_hit == 3'd4 ? BAR4SIZE : BAR5SIZE;
        bar_mask = (64'd1 << bar_size) - 64'd1;
        bar_addr = (bar_base & ~bar_mask) | ({32'd0, mem_req_pcie_address} & bar_mask & ~64'd3);
        mapped   = mem_req_bar_hit < 3'd6;
        // A new AR may only load when the AR slot is free or draining this cycle
        mem_req_ready = !m_axi_areset && cnt_q < 5'(MAX_OUTSTANDING) && (!arvalid_q || m_axi_arready);
        accept    = mem_req_valid && mem_req_ready && !mem_req_write_readn;
        arvalid_d = (accept && mapped) ? 1'b1 : (m_axi_arready ? 1'b0 : arvalid_q);
        araddr_d  = (accept && mapped) ? bar_addr[AW-1:0] : araddr_q;
        head      = fifo_q[rptr_q];
        empty     = cnt_q == 5'd0;
        rdata64   = 64'(m_axi_rdata);
        cpl_valid    = !empty && (head.ur || m_axi_rvalid);
        m_axi_rready = !empty && !head.ur && cpl_ready;
        cpl_data     = (empty || head.ur) ? 32'd0 :
                       (AXI_DATA_WIDTH == 64 && head.lane) ? rdata64[63:32] : rdata64[31:0];
        cpl_status   = empty ? 2'b00 : head.ur ? 2'b01 : {m_axi_rresp[1], 1'b0};
        cpl_byte_enable = empty ? 4'd0 : head.be;
        cpl_phys_func   = !empty && head.func;
        pop   = cpl_valid && cpl_ready;
        cnt_d = cnt_q + 5'(accept) - 5'(pop);
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            wptr_q    <= accept ? nxt(wptr_q) : wptr_q;
            rptr_q    <= pop ? nxt(rptr_q) : rptr_q;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (accept)
            fifo_q[wptr_q] <= {!mapped, mem_req_pcie_address[2], mem_req_byte_enable, mem_req_phys_func};
    end

    assign m_axi_araddr    = phy_addr[AW-1:0] + araddr_q;
    assign m_axi_arprot    = 3'b000;
    assign m_axi_arvalid   = arvalid_q;
    assign outstanding_cnt = cnt_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_rresp[0], phy_addr, bar_addr, rdata64};
endmodule

// File: doc/pcie_axi_read_engine.md
# pcie_axi_read_engine

Pipelined successor to the PCIe-to-AXI-Lite read controller in the pcie2axilite bridge. It sits between the TLP request decoder and the AXI-Lite master port. It keeps up to MAX_OUTSTANDING reads in flight, with back-to-back AR issue and in-order completion pairing. It selects a 32-bit lane from 32- or 64-bit AXI data, maps AXI errors to completion status, and generates Unsupported Request (UR) completions for unmapped BAR hits without touching AXI.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 49, width of m_axi_araddr
- AXI_DATA_WIDTH, 64, R data width; legal values 32 or 64
- MAX_OUTSTANDING, 4, metadata FIFO depth and in-flight read limit; power of 2, range 1..16
- BAR0AXI..BAR5AXI, 64'h0, AXI base address for each BAR; bits above BARnSIZE are used
- BAR0SIZE..BAR5SIZE, 12, log2 of the aperture size of each BAR

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_areset  in  1  reset, synchronous, active-high.
- m_axi_araddr  out  AXI_ADDR_WIDTH  read address.
- m_axi_arprot  out  3  constant 0.
- m_axi_arvalid / m_axi_arready  out/in  1  AR handshake.
- m_axi_rdata  in  AXI_DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid / m_axi_rready  in/out  1  R handshake.
- mem_req_valid / mem_req_ready  in/out  1  request handshake.
- mem_req_bar_hit  in  3  BAR index; 6 and 7 are unmapped.
- mem_req_pcie_address  in  32  TLP address.
- mem_req_byte_enable  in  4  first DW byte enables.
- mem_req_write_readn  in  1  1 = write; writes are ignored by this block.
- mem_req_phys_func  in  1  function number.
- phy_addr  in  64  AXI offset added to every translated address; quasi-static.
- cpl_valid / cpl_ready  out/in  1  completion handshake.
- cpl_data  out  32  completion DW.
- cpl_byte_enable  out  4  copied from the request.
- cpl_phys_func  out  1  copied from the request.
- cpl_status  out  2  00 = SC, 01 = UR, 10 = CA.
- outstanding_cnt  out  5  number of occupied metadata FIFO entries.

## Operation
- Accept: a request is accepted when mem_req_valid & mem_req_ready & !mem_req_write_readn.
  - mem_req_ready = !reset & (cnt < MAX_OUTSTANDING) & (!m_axi_arvalid | m_axi_arready).
- Translation, BAR n in 0..5: addr = {BARnAXI[AXI_ADDR_WIDTH-1:BARnSIZE], pcie_address[BARnSIZE-1:2], 2'b00}. m_axi_araddr = phy_addr[AXI_ADDR_WIDTH-1:0] + addr, truncated modulo 2^AXI_ADDR_WIDTH. Registered at accept.
- Mapped hit:
  - Load the AR register and set arvalid.
  - arvalid holds, with stable address, until arready. It is then cleared, unless a new mapped request is accepted in the same cycle, in which case it reloads.
- Unmapped hit (6/7): no AR is issued; the AR register is untouched even if arvalid is pending.
- Every accepted read pushes {ur, lane = pcie_address[2], be, func} into the metadata FIFO.
- Completion path, driven from the FIFO head:
  - Head ur = 1: cpl_valid = 1, cpl_data = 0, cpl_status = 01, m_axi_rready = 0.
  - Head ur = 0: cpl_valid = m_axi_rvalid and m_axi_rready = cpl_ready. cpl_data = rdata[63:32] if lane = 1 and AXI_DATA_WIDTH = 64, else rdata[31:0]. cpl_status = rresp[1] ? 10 : 00.
  - FIFO empty: cpl_valid = 0, m_axi_rready = 0. A stray rvalid is stalled, never consumed.
- Pop on cpl_valid & cpl_ready. Push and pop in the same cycle leave cnt unchanged. cnt never exceeds MAX_OUTSTANDING.
- Completions leave in acceptance order, with UR completions interleaved in order.

## Timing
- Reset values: m_axi_arvalid 0, m_axi_araddr = phy_addr truncated (register 0), m_axi_rready 0, mem_req_ready 0, cpl_valid 0, cpl_data 0, cpl_status 00, outstanding_cnt 0. The FIFO is flushed.
- mem_req_ready rises the first cycle after reset deasserts.
- Reset mid-operation drops all in-flight metadata. Late R beats arriving after reset are stalled with rready = 0.
- Accept to arvalid: 1 cycle.
- Throughput: sustained arready allows one AR per cycle.
- R to completion: combinational, 0 cycles. rdata and rresp flow straight through to cpl_data and cpl_status.
- UR completion: valid the cycle after accept, if the FIFO was empty.
- Full FIFO: mem_req_ready = 0. It reasserts the cycle a pop lowers cnt.

## Test plan
- Single read, BAR0AXI = 0x4000, BAR0SIZE = 12, phy_addr = 0x1_0000_0000, address 0x123 -> araddr 0x1_0000_4120 one cycle after accept; rdata 0xAABBCCDD_11223344 returns cpl_data 0x11223344 with status 00.
- Four back-to-back reads with arready held high, R withheld -> four ARs on consecutive cycles, mem_req_ready = 0 and outstanding_cnt = 4; returning R beats drain in order and ready reasserts.
- bar_hit = 7 issued between two BAR1 reads -> only two ARs; completions arrive in order SC, UR (data 0, status 01), SC.
- rresp = 2'b10 with address bit 2 = 1 -> cpl_status 10, cpl_data = rdata[63:32].
- cpl_ready low for 5 cycles while rvalid is high -> rready stays 0 and rdata is held; one pop follows on release.
- Reset asserted with 3 reads in flight -> all outputs return to reset values and outstanding_cnt = 0; a stray rvalid afterwards leaves rready = 0.
